pipe_mac: RTL and testbench



---
 rtl/pipe_mac.sv | 152 +++++++++++++++
 tb/tb_pipe_mac.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_mac.sv
`default_nettype none
// ============================================================================
// Module   : pipe_mac
// Purpose  : Pipelined multiply / multiply-accumulate with valid/ready flow,
//            per-beat signed mode, sticky overflow and frame-last tagging.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_mac #(
   parameter int N      = 8,
   parameter int STAGES = 3,
   parameter int ACC_W  = 2*N+4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     in_a,
   input  logic [N-1:0]     in_b,
   input  logic             in_signed,
   input  logic             in_acc,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_p,
   output logic             out_last,
   output logic             out_ovf
);

   localparam int c_PROD_W = 2*N;
   localparam int c_LAST   = STAGES-1;

   logic                r_s1_valid;
   logic [N-1:0]        r_s1_a;
   logic [N-1:0]        r_s1_b;
   logic                r_s1_signed;
   logic                r_s1_acc;
   logic                r_s1_last;

   logic [ACC_W-1:0]    r_d_p      [1:STAGES-1];
   logic                r_d_valid  [1:STAGES-1];
   logic                r_d_signed [1:STAGES-1];
   logic                r_d_acc    [1:STAGES-1];
   logic                r_d_last   [1:STAGES-1];

   logic [ACC_W-1:0]    r_acc;
   logic                r_out_valid;
   logic                r_out_last;
   logic                r_out_ovf;

   logic                w_advance;
   logic [c_PROD_W-1:0] w_a_x;
   logic [c_PROD_W-1:0] w_b_x;
   logic [c_PROD_W-1:0] w_prod;
   logic [ACC_W-1:0]    w_ext;
   logic [ACC_W:0]      w_sum;
   logic                w_ovf_add;

   assign w_advance = !(r_out_valid && !out_ready);
   assign in_ready  = w_advance;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid  <= 1'b0;
         r_s1_a      <= '0;
         r_s1_b      <= '0;
         r_s1_signed <= 1'b0;
         r_s1_acc    <= 1'b0;
         r_s1_last   <= 1'b0;
      end else if (w_advance) begin
         r_s1_valid  <= in_valid;
         r_s1_a      <= in_a;
         r_s1_b      <= in_b;
         r_s1_signed <= in_signed;
         r_s1_acc    <= in_acc;
         r_s1_last   <= in_last;
      end
   end

   // Extending both operands to 2N bits per mode lets one multiplier serve
   // signed and unsigned beats: the low 2N bits are correct either way.
   assign w_a_x  = {{N{r_s1_signed & r_s1_a[N-1]}}, r_s1_a};
   assign w_b_x  = {{N{r_s1_signed & r_s1_b[N-1]}}, r_s1_b};
   assign w_prod = w_a_x * w_b_x;

   generate
      if (ACC_W > c_PROD_W) begin : g_ext_wide
         assign w_ext = {{(ACC_W-c_PROD_W){r_s1_signed & w_prod[c_PROD_W-1]}}, w_prod};
      end else begin : g_ext_exact
         assign w_ext = w_prod;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 1; i < STAGES; i++) begin
            r_d_p[i]      <= '0;
            r_d_valid[i]  <= 1'b0;
            r_d_signed[i] <= 1'b0;
            r_d_acc[i]    <= 1'b0;
            r_d_last[i]   <= 1'b0;
         end
      end else if (w_advance) begin
         r_d_p[1]      <= w_ext;
         r_d_valid[1]  <= r_s1_valid;
         r_d_signed[1] <= r_s1_signed;
         r_d_acc[1]    <= r_s1_acc;
         r_d_last[1]   <= r_s1_last;
         for (int i = 2; i < STAGES; i++) begin
            r_d_p[i]      <= r_d_p[i-1];
            r_d_valid[i]  <= r_d_valid[i-1];
            r_d_signed[i] <= r_d_signed[i-1];
            r_d_acc[i]    <= r_d_acc[i-1];
            r_d_last[i]   <= r_d_last[i-1];
         end
      end
   end

   // Signed overflow: like-signed addends whose sum flips sign.
   assign w_sum     = {1'b0, r_acc} + {1'b0, r_d_p[c_LAST]};
   assign w_ovf_add = r_d_signed[c_LAST]
                    ? ((r_acc[ACC_W-1] == r_d_p[c_LAST][ACC_W-1]) &&
                       (w_sum[ACC_W-1] != r_acc[ACC_W-1]))
                    : w_sum[ACC_W];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc       <= '0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_out_ovf   <= 1'b0;
      end else if (w_advance) begin
         r_out_valid <= r_d_valid[c_LAST];
         if (r_d_valid[c_LAST]) begin
            r_out_last <= r_d_last[c_LAST];
            if (r_d_acc[c_LAST]) begin
               r_acc     <= w_sum[ACC_W-1:0];
               r_out_ovf <= r_out_ovf | w_ovf_add;
            end else begin
               r_acc     <= r_d_p[c_LAST];
               r_out_ovf <= 1'b0;
            end
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_p     = r_acc;
   assign out_last  = r_out_last;
   assign out_ovf   = r_out_ovf;

endmodule
`default_nettype wire

// File: tb/tb_pipe_mac.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_mac
// Purpose  : Randomised and directed bench for pipe_mac against a scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_mac;

   localparam int N      = 8;
   localparam int STAGES = 3;
   localparam int ACC_W  = 20;

   localparam longint c_MOD  = 64'sd1 << ACC_W;
   localparam longint c_MASK = c_MOD - 1;
   localparam longint c_HALF = c_MOD >> 1;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [N-1:0]     in_a;
   logic [N-1:0]     in_b;
   logic             in_signed;
   logic             in_acc;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] out_p;
   logic             out_last;
   logic             out_ovf;

   pipe_mac #(.N(N), .STAGES(STAGES), .ACC_W(ACC_W)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_signed (in_signed),
      .in_acc    (in_acc),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_p     (out_p),
      .out_last  (out_last),
      .out_ovf   (out_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      longint p;
      bit     last;
      bit     ovf;
      int     edge_no;
   } exp_t;

   exp_t   r_q[$];
   longint r_log_p[$];
   bit     r_log_last[$];
   bit     r_log_ovf[$];
   int     r_log_edge[$];

   int     r_n_vec = 0;
   int     r_n_err = 0;
   int     r_edge = 0;
   int     r_last_stall_edge = 0;
   longint r_m_sum = 0;
   bit     r_m_ovf = 0;
   bit     r_prev_stall = 0;
   longint r_held_p;
   bit     r_held_last;
   bit     r_held_ovf;

   task automatic chk(input string tag, input longint obs, input longint exp);
      r_n_vec++;
      if (obs != exp) begin
         r_n_err++;
         $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic longint lp(input int i);
      return (i < r_log_p.size()) ? r_log_p[i] : -1;
   endfunction
   function automatic int ll(input int i);
      return (i < r_log_last.size()) ? int'(r_log_last[i]) : -1;
   endfunction
   function automatic int lo(input int i);
      return (i < r_log_ovf.size()) ? int'(r_log_ovf[i]) : -1;
   endfunction

   task automatic clear_log();
      r_log_p.delete();
      r_log_last.delete();
      r_log_ovf.delete();
      r_log_edge.delete();
   endtask

   // Reference: exact integer product and sum, overflow by range test.
   task automatic model_push(input logic [N-1:0] a, input logic [N-1:0] b,
                             input bit s, input bit acc, input bit last);
      longint pa, pb, ext, sv, ev, r;
      exp_t e;
      if (s) begin
         pa = longint'($signed(a));
         pb = longint'($signed(b));
      end else begin
         pa = longint'(a);
         pb = longint'(b);
      end
      ext = (pa * pb) & c_MASK;
      if (!acc) begin
         r_m_sum = ext;
         r_m_ovf = 0;
      end else if (s) begin
         sv = (r_m_sum >= c_HALF) ? r_m_sum - c_MOD : r_m_sum;
         ev = (ext >= c_HALF) ? ext - c_MOD : ext;
         r  = sv + ev;
         if (r >= c_HALF || r < -c_HALF) r_m_ovf = 1;
         r_m_sum = r & c_MASK;
      end else begin
         r = r_m_sum + ext;
         if (r >= c_MOD) r_m_ovf = 1;
         r_m_sum = r & c_MASK;
      end
      e.p = r_m_sum;
      e.last = last;
      e.ovf = r_m_ovf;
      e.edge_no = r_edge + 1;
      r_q.push_back(e);
   endtask

   task automatic step(input logic v, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic s, input logic acc, input logic last,
                       input logic ordy, input bit rst_pulse, output bit took);
      exp_t e;
      in_valid  = v;
      in_a      = a;
      in_b      = b;
      in_signed = s;
      in_acc    = acc;
      in_last   = last;
      out_ready = ordy;
      if (rst_pulse) begin
         #2 rst_n = 1'b0;
         #1;
         chk("rst_async_valid", out_valid, 0);
         chk("rst_async_p", out_p, 0);
         chk("rst_async_ovf", out_ovf, 0);
         r_q.delete();
         r_m_sum = 0;
         r_m_ovf = 0;
         r_prev_stall = 0;
         #1 rst_n = 1'b1;
      end else begin
         #1;
      end
      if (r_prev_stall) begin
         chk("hold_valid", out_valid, 1);
         chk("hold_p", out_p, r_held_p);
         chk("hold_last", out_last, r_held_last);
         chk("hold_ovf", out_ovf, r_held_ovf);
      end
      chk("in_ready", in_ready, (out_valid && !out_ready) ? 0 : 1);
      if (out_valid && out_ready) begin
         if (r_q.size() == 0) begin
            chk("spurious_out", 1, 0);
         end else begin
            e = r_q.pop_front();
            chk("out_p", out_p, e.p);
            chk("out_last", out_last, e.last);
            chk("out_ovf", out_ovf, e.ovf);
            if (r_last_stall_edge <= e.edge_no)
               chk("latency", r_edge - e.edge_no, STAGES);
            r_log_p.push_back(longint'(out_p));
            r_log_last.push_back(out_last);
            r_log_ovf.push_back(out_ovf);
            r_log_edge.push_back(r_edge);
         end
      end
      r_prev_stall = out_valid && !out_ready;
      if (r_prev_stall) begin
         r_held_p          = longint'(out_p);
         r_held_last       = out_last;
         r_held_ovf        = out_ovf;
         r_last_stall_edge = r_edge + 1;
      end
      took = v && in_ready;
      if (took) model_push(a, b, s, acc, last);
      @(posedge clk);
      r_edge++;
      @(negedge clk);
   endtask

   task automatic beat(input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic s, input logic acc, input logic last);
      bit t;
      step(1'b1, a, b, s, acc, last, 1'b1, 1'b0, t);
      if (!t) chk("beat_accept", 0, 1);
   endtask

   task automatic idle(input int n);
      bit t;
      for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, t);
   endtask

   initial begin
      bit t;
      int i, cyc;
      rst_n = 1'b0;
      in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0;
      in_acc = 1'b0; in_last = 1'b0; out_ready = 1'b1;
      #1;
      chk("reset_valid", out_valid, 0);
      chk("reset_p", out_p, 0);
      chk("reset_last", out_last, 0);
      chk("reset_ovf", out_ovf, 0);
      chk("reset_in_ready", in_ready, 1);
      #11 rst_n = 1'b1;
      @(negedge clk);

      // single beat
      clear_log();
      beat(8'd3, 8'd5, 1'b0, 1'b0, 1'b0);
      idle(6);
      chk("t1_count", r_log_p.size(), 1);
      chk("t1_p", lp(0), 15);

      // signed / unsigned extension
      clear_log();
      beat(8'hFF, 8'h02, 1'b1, 1'b0, 1'b0);
      beat(8'hFF, 8'h02, 1'b0, 1'b0, 1'b0);
      beat(8'h80, 8'h80, 1'b1, 1'b0, 1'b0);
      idle(6);
      chk("t2_signed_neg", lp(0), 20'hFFFFE);
      chk("t2_unsigned", lp(1), 510);
      chk("t2_signed_min", lp(2), 16384);

      // back-to-back accumulation
      clear_log();
      beat(8'd10, 8'd10, 1'b0, 1'b0, 1'b0);
      beat(8'd20, 8'd20, 1'b0, 1'b1, 1'b0);
      beat(8'd30, 8'd30, 1'b0, 1'b1, 1'b1);
      idle(6);
      chk("t3_p0", lp(0), 100);
      chk("t3_p1", lp(1), 500);
      chk("t3_p2", lp(2), 1400);
      chk("t3_last0", ll(0), 0);
      chk("t3_last2", ll(2), 1);
      chk("t3_ovf2", lo(2), 0);
      chk("t3_consecutive", (r_log_edge.size() == 3) ? r_log_edge[2] - r_log_edge[0] : -1, 2);

      // unsigned overflow, stickiness and clear
      clear_log();
      for (int k = 0; k < 17; k++) beat(8'hFF, 8'hFF, 1'b0, (k != 0), 1'b0);
      beat(8'd1, 8'd1, 1'b0, 1'b1, 1'b0);
      beat(8'd1, 8'd1, 1'b0, 1'b0, 1'b0);
      idle(6);
      chk("t4_p16th", lp(15), 1040400);
      chk("t4_ovf16th", lo(15), 0);
      chk("t4_p17th", lp(16), 56849);
      chk("t4_ovf17th", lo(16), 1);
      chk("t4_p_sticky", lp(17), 56850);
      chk("t4_ovf_sticky", lo(17), 1);
      chk("t4_p_restart", lp(18), 1);
      chk("t4_ovf_restart", lo(18), 0);

      // backpressure mid-stream
      clear_log();
      i = 0;
      cyc = 0;
      while (i < 12 && cyc < 100) begin
         step(1'b1, 8'(i+1), 8'(i+2), 1'b0, (i != 0), (i == 11),
              !(cyc >= 5 && cyc < 9), 1'b0, t);
         if (t) i++;
         cyc++;
      end
      if (cyc >= 100) chk("t5_timeout", 0, 1);
      idle(8);
      chk("t5_count", r_log_p.size(), 12);
      chk("t5_final", lp(11), 728);
      chk("t5_final_last", ll(11), 1);

      // asynchronous reset with beats in flight
      clear_log();
      beat(8'd10, 8'd10, 1'b0, 1'b0, 1'b0);
      beat(8'd20, 8'd20, 1'b0, 1'b1, 1'b0);
      beat(8'd1, 8'd1, 1'b0, 1'b1, 1'b0);
      beat(8'd2, 8'd2, 1'b0, 1'b1, 1'b0);
      idle(1);
      chk("t6_partial_valid", out_valid, 1);
      chk("t6_partial_p", out_p, 500);
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, t);
      idle(6);
      chk("t6_flushed", r_log_p.size(), 1);
      beat(8'd4, 8'd4, 1'b0, 1'b1, 1'b0);
      idle(6);
      chk("t6_after_reset", lp(1), 16);

      // randomised traffic
      for (int k = 0; k < 600; k++) begin
         step(($urandom_range(99) < 70), 8'($urandom), 8'($urandom),
              1'($urandom), ($urandom_range(99) < 85), 1'($urandom),
              ($urandom_range(99) < 70), 1'b0, t);
      end
      idle(10);
      chk("drain_empty", r_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", r_n_vec, r_n_err);
      $finish;
   end

endmodule
`default_nettype wire
